// File: rtl/mem_access_pkg.sv
// mem_access_pkg
// Shared types and helpers for the MEM pipeline stage:
//   loadType_e / storeType_e : encodings of the load/store width fields
//   state_e                  : request/response sequencing states
//   accessBytes()            : access size in bytes for a load or store
//   strobeMask()             : byte-enable pattern for a size at a byte offset
package mem_access_pkg;

    localparam int BUS_BYTES = 8;

    typedef enum logic [2:0] {
        LT_LB   = 3'd0,
        LT_LH   = 3'd1,
        LT_LW   = 3'd2,
        LT_LD   = 3'd3,
        LT_LBU  = 3'd4,
        LT_LHU  = 3'd5,
        LT_LWU  = 3'd6,
        LT_RSVD = 3'd7   // behaves as LD
    } loadType_e;

    typedef enum logic [1:0] {
        ST_SB = 2'd0,
        ST_SH = 2'd1,
        ST_SW = 2'd2,
        ST_SD = 2'd3
    } storeType_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2
    } state_e;

    // Number of bytes touched by the access (1, 2, 4 or 8).
    function automatic logic [3:0] accessBytes(input logic isLoad,
                                               input logic [2:0] loadType,
                                               input logic [1:0] storeType);
        logic [3:0] nBytes;
        if (isLoad) begin
            case (loadType_e'(loadType))
                LT_LB, LT_LBU: nBytes = 4'd1;
                LT_LH, LT_LHU: nBytes = 4'd2;
                LT_LW, LT_LWU: nBytes = 4'd4;
                default:       nBytes = 4'd8;
            endcase
        end else begin
            case (storeType_e'(storeType))
                ST_SB:   nBytes = 4'd1;
                ST_SH:   nBytes = 4'd2;
                ST_SW:   nBytes = 4'd4;
                default: nBytes = 4'd8;
            endcase
        end
        return nBytes;
    endfunction

    // Byte enables for an access of nBytes starting at lane off.
    // Callers only use this for accesses that fit inside the word.
    function automatic logic [BUS_BYTES-1:0] strobeMask(input logic [3:0] nBytes,
                                                        input logic [2:0] off);
        logic [BUS_BYTES-1:0] base;
        case (nBytes)
            4'd1:    base = 8'h01;
            4'd2:    base = 8'h03;
            4'd4:    base = 8'h0F;
            default: base = 8'hFF;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/mem_access_load_extender.sv
// mem_access_load_extender
// Combinational load-data formatter: pulls the addressed bytes out of an
// aligned 8-byte memory word and sign- or zero-extends them to 64 bits.
//   word     : aligned 64-bit word returned by memory
//   off      : byte offset of the access within the word
//   loadType : load width/signedness (loadType_e)
//   extended : register-ready 64-bit value
module mem_access_load_extender
    import mem_access_pkg::*;
(
    input  logic [63:0] word,
    input  logic [2:0]  off,
    input  logic [2:0]  loadType,
    output logic [63:0] extended
);

    logic [63:0] shifted;

    // Bring the addressed byte down to lane 0.
    assign shifted = word >> {off, 3'b000};

    always_comb begin
        case (loadType_e'(loadType))
            LT_LB:   extended = {{56{shifted[7]}},  shifted[7:0]};
            LT_LH:   extended = {{48{shifted[15]}}, shifted[15:0]};
            LT_LW:   extended = {{32{shifted[31]}}, shifted[31:0]};
            LT_LBU:  extended = {56'd0, shifted[7:0]};
            LT_LHU:  extended = {48'd0, shifted[15:0]};
            LT_LWU:  extended = {32'd0, shifted[31:0]};
            default: extended = shifted;    // LD and the reserved code
        endcase
    end

endmodule

// File: rtl/mem_access.sv
// mem_access
// MEM pipeline stage. Accepts one instruction at a time from execute, issues
// the data-memory request on a valid/ready channel, waits for load data on the
// response channel and produces one registered writeback beat per instruction.
//   clk, reset                 : clock, asynchronous active-high reset
//   inValid .. inDataReg2      : execute-stage instruction fields
//   outStall                   : upstream must hold; inValid ignored while high
//   outReq* / inReqReady       : memory request channel (aligned address, lane data, strobes)
//   inRespValid / inRespData   : memory load response
//   outValid .. outMisaligned  : writeback beat
module mem_access
    import mem_access_pkg::*;
#(
    parameter int BUS_DATA_WIDTH = 64   // fixed at 64: eight byte lanes
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        inValid,
    input  logic                        inMemRead,
    input  logic                        inMemWrite,
    input  logic                        inMemOrReg,
    input  logic                        inRegWrite,
    input  logic [4:0]                  inDestRegister,
    input  logic [2:0]                  inLoadType,
    input  logic [1:0]                  inStoreType,
    input  logic [BUS_DATA_WIDTH-1:0]   inResult,
    input  logic [BUS_DATA_WIDTH-1:0]   inDataReg2,
    output logic                        outStall,
    output logic                        outReqValid,
    input  logic                        inReqReady,
    output logic [BUS_DATA_WIDTH-1:0]   outReqAddr,
    output logic                        outReqWrite,
    output logic [BUS_DATA_WIDTH-1:0]   outReqWdata,
    output logic [BUS_DATA_WIDTH/8-1:0] outReqStrb,
    input  logic                        inRespValid,
    input  logic [BUS_DATA_WIDTH-1:0]   inRespData,
    output logic                        outValid,
    output logic                        outRegWrite,
    output logic [4:0]                  outDestRegister,
    output logic [BUS_DATA_WIDTH-1:0]   outWbData,
    output logic                        outMisaligned
);

    state_e                      stateReg;
    logic                        capMemOrReg;
    logic                        capRegWrite;
    logic [4:0]                  capDest;
    logic [2:0]                  capLoadType;
    logic [2:0]                  capOff;
    logic [BUS_DATA_WIDTH-1:0]   capResult;

    logic                        isMem;
    logic [2:0]                  inOff;
    logic [3:0]                  inBytes;
    logic                        inMisaligned;
    logic [BUS_DATA_WIDTH-1:0]   loadValue;

    assign isMem   = inMemRead | inMemWrite;
    assign inOff   = inResult[2:0];
    assign inBytes = accessBytes(inMemRead, inLoadType, inStoreType);
    // Access spills into the next word when offset + size passes 8 bytes.
    assign inMisaligned = ({1'b0, inOff} + inBytes) > 4'd8;

    // Stall follows the registered state, so it drops on the same edge
    // that raises outValid and a new instruction can enter that cycle.
    assign outStall = (stateReg != S_IDLE);

    mem_access_load_extender loadExtender (
        .word     (inRespData),
        .off      (capOff),
        .loadType (capLoadType),
        .extended (loadValue)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stateReg        <= S_IDLE;
            outReqValid     <= 1'b0;
            outReqWrite     <= 1'b0;
            outReqAddr      <= '0;
            outReqWdata     <= '0;
            outReqStrb      <= '0;
            outValid        <= 1'b0;
            outRegWrite     <= 1'b0;
            outDestRegister <= '0;
            outWbData       <= '0;
            outMisaligned   <= 1'b0;
            capMemOrReg     <= 1'b0;
            capRegWrite     <= 1'b0;
            capDest         <= '0;
            capLoadType     <= '0;
            capOff          <= '0;
            capResult       <= '0;
        end else begin
            outValid <= 1'b0;   // writeback is a single-cycle beat
            case (stateReg)
                S_IDLE: begin
                    if (inValid) begin
                        capMemOrReg <= inMemOrReg;
                        capRegWrite <= inRegWrite;
                        capDest     <= inDestRegister;
                        capLoadType <= inLoadType;
                        capOff      <= inOff;
                        capResult   <= inResult;
                        if (!isMem || inMisaligned) begin
                            // No memory traffic: retire on the next edge.
                            outValid        <= 1'b1;
                            outDestRegister <= inDestRegister;
                            outWbData       <= inResult;
                            outMisaligned   <= isMem;
                            outRegWrite     <= isMem ? 1'b0 : inRegWrite;
                        end else begin
                            stateReg    <= S_REQ;
                            outReqValid <= 1'b1;
                            outReqWrite <= inMemWrite;
                            outReqAddr  <= {inResult[BUS_DATA_WIDTH-1:3], 3'b000};
                            outReqWdata <= inDataReg2 << {inOff, 3'b000};
                            outReqStrb  <= strobeMask(inBytes, inOff);
                        end
                    end
                end
                S_REQ: begin
                    if (inReqReady) begin
                        outReqValid <= 1'b0;
                        if (outReqWrite) begin
                            stateReg        <= S_IDLE;
                            outValid        <= 1'b1;
                            outRegWrite     <= 1'b0;
                            outMisaligned   <= 1'b0;
                            outDestRegister <= capDest;
                            outWbData       <= capResult;
                        end else begin
                            stateReg <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (inRespValid) begin
                        stateReg        <= S_IDLE;
                        outValid        <= 1'b1;
                        outRegWrite     <= capRegWrite;
                        outMisaligned   <= 1'b0;
                        outDestRegister <= capDest;
                        outWbData       <= capMemOrReg ? loadValue : capResult;
                    end
                end
                default: stateReg <= S_IDLE;
            endcase
        end
    end

endmodule
